board_state_keeper: RTL and testbench

- Owns the 10x10 battleship board state and produces the 200-bit `cell_status_flat` bus that the display renderer consumes.
- Ships are loaded during a setup phase. After setup, one shot is accepted at a time through a valid/ready handshake.
- Each shot is classified as miss, hit, sunk or repeat, and per-cell status is updated to match. When a ship is sunk, all of its cells are rewritten to "sunk".

---
 rtl/board_state_keeper.sv | 156 +++++++++++++++
 tb/tb_board_state_keeper.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_state_keeper.sv
// Battleship board keeper: ship map, per-cell status, shot classification.
// Sinking a ship rewrites all of its cells with a 100-cycle sweep.
module board_state_keeper #(
  parameter int NUM_SHIPS = 5,
  parameter int GRID_N    = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         place_we,
  input  logic [3:0]                   place_row,
  input  logic [3:0]                   place_col,
  input  logic [2:0]                   place_id,
  input  logic                         start,
  input  logic                         fire_valid,
  input  logic [3:0]                   fire_row,
  input  logic [3:0]                   fire_col,
  output logic                         fire_ready,
  output logic                         result_valid,
  output logic [1:0]                   result,
  output logic [2*GRID_N*GRID_N-1:0]   cell_status_flat,
  output logic [2:0]                   ships_left,
  output logic                         game_over
);

  localparam int CELLS = GRID_N * GRID_N;

  typedef enum logic [2:0] {
    SETUP, PLAY, CHECK, SCAN, REPORT, DONE
  } state_t;

  state_t     state, state_nx;
  logic [2:0] idmap  [CELLS];
  logic [1:0] status [CELLS];
  logic [6:0] cnt    [8];
  logic [3:0] row_q, col_q;
  logic [2:0] kid;
  logic [6:0] scan_idx;
  logic [2:0] nz;
  logic [6:0] p_idx, f_idx;
  logic       p_in, p_ok, f_in, f_fresh, f_sink;

  assign p_in  = (place_row < 4'(GRID_N)) && (place_col < 4'(GRID_N));
  assign p_idx = p_in ? 7'(place_row) * 7'(GRID_N) + 7'(place_col) : '0;
  assign p_ok  = place_we && p_in && (place_id != 3'd0)
              && (place_id <= 3'(NUM_SHIPS)) && (idmap[p_idx] == 3'd0);

  assign f_in    = (row_q < 4'(GRID_N)) && (col_q < 4'(GRID_N));
  assign f_idx   = f_in ? 7'(row_q) * 7'(GRID_N) + 7'(col_q) : '0;
  assign f_fresh = f_in && (status[f_idx] == 2'b00);
  assign f_sink  = f_fresh && (idmap[f_idx] != 3'd0)
                && (cnt[idmap[f_idx]] == 7'd1);

  // Count ships that still have at least one placed cell.
  always_comb begin
    nz = '0;
    for (int i = 1; i <= NUM_SHIPS; i++)
      if (cnt[i] != 7'd0) nz = nz + 3'd1;
  end

  // Expose the status array as the flat render bus.
  always_comb begin
    cell_status_flat = '0;
    for (int i = 0; i < CELLS; i++)
      cell_status_flat[i*2 +: 2] = status[i];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= SETUP;
    else        state <= state_nx;
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    unique case (state)
      SETUP:  if (start && nz != 3'd0) state_nx = PLAY;
      PLAY:   if (fire_valid && fire_ready) state_nx = CHECK;
      CHECK:  state_nx = f_sink ? SCAN : REPORT;
      SCAN:   if (scan_idx == 7'(CELLS - 1)) state_nx = REPORT;
      REPORT: state_nx = game_over ? DONE : PLAY;
      DONE:   state_nx = DONE;
      default: state_nx = SETUP;
    endcase
  end

  // Board, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) begin
        idmap[i]  <= '0;
        status[i] <= '0;
      end
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
      row_q        <= '0;
      col_q        <= '0;
      kid          <= '0;
      scan_idx     <= '0;
      fire_ready   <= 1'b0;
      result_valid <= 1'b0;
      result       <= 2'b00;
      ships_left   <= '0;
      game_over    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      fire_ready   <= (state_nx == PLAY);
      unique case (state)
        SETUP: begin
          if (p_ok) begin
            idmap[p_idx]  <= place_id;
            cnt[place_id] <= cnt[place_id] + 7'd1;
          end
          if (state_nx == PLAY) ships_left <= nz;
        end
        PLAY: begin
          if (fire_valid && fire_ready) begin
            row_q <= fire_row;
            col_q <= fire_col;
          end
        end
        CHECK: begin
          if (!f_fresh) begin
            result       <= 2'b00;
            result_valid <= 1'b1;
          end else if (idmap[f_idx] == 3'd0) begin
            status[f_idx] <= 2'b01;
            result        <= 2'b01;
            result_valid  <= 1'b1;
          end else begin
            status[f_idx]     <= 2'b10;
            kid               <= idmap[f_idx];
            cnt[idmap[f_idx]] <= cnt[idmap[f_idx]] - 7'd1;
            if (f_sink) begin
              scan_idx <= '0;
            end else begin
              result       <= 2'b10;
              result_valid <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (idmap[scan_idx] == kid) status[scan_idx] <= 2'b11;
          scan_idx <= scan_idx + 7'd1;
          if (scan_idx == 7'(CELLS - 1)) begin
            ships_left   <= ships_left - 3'd1;
            result       <= 2'b11;
            result_valid <= 1'b1;
            if (ships_left == 3'd1) game_over <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_state_keeper.sv
// Randomized bench for board_state_keeper against a cell/ship level model.
// Sinking is judged by whether any cell of the ship is still untouched.
module tb_board_state_keeper;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         place_we;
  logic [3:0]   place_row, place_col;
  logic [2:0]   place_id;
  logic         start;
  logic         fire_valid;
  logic [3:0]   fire_row, fire_col;
  logic         fire_ready, result_valid, game_over;
  logic [1:0]   result;
  logic [199:0] cell_status_flat;
  logic [2:0]   ships_left;

  int checks = 0;
  int failures = 0;

  int m_map  [100];
  int m_stat [100];
  int m_left;
  bit m_over;

  always #5 clk = ~clk;

  board_state_keeper dut (
    .clk(clk), .rst_n(rst_n),
    .place_we(place_we), .place_row(place_row),
    .place_col(place_col), .place_id(place_id),
    .start(start), .fire_valid(fire_valid),
    .fire_row(fire_row), .fire_col(fire_col),
    .fire_ready(fire_ready), .result_valid(result_valid),
    .result(result), .cell_status_flat(cell_status_flat),
    .ships_left(ships_left), .game_over(game_over)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [199:0] model_flat();
    logic [199:0] f;
    f = '0;
    for (int i = 0; i < 100; i++) f[i*2 +: 2] = 2'(m_stat[i]);
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 100; i++) begin
      m_map[i] = 0;
      m_stat[i] = 0;
    end
    m_left = 0;
    m_over = 0;
  endtask

  function automatic int ships_on_board();
    int n;
    n = 0;
    for (int k = 1; k <= 5; k++)
      for (int i = 0; i < 100; i++)
        if (m_map[i] == k) begin
          n++;
          break;
        end
    return n;
  endfunction

  task automatic model_shot(input int r, input int c,
                            output int res, output int lat);
    int idx, k;
    bit untouched;
    lat = 1;
    if (r >= 10 || c >= 10) begin
      res = 0;
      return;
    end
    idx = r * 10 + c;
    if (m_stat[idx] != 0) begin
      res = 0;
    end else if (m_map[idx] == 0) begin
      m_stat[idx] = 1;
      res = 1;
    end else begin
      k = m_map[idx];
      m_stat[idx] = 2;
      untouched = 0;
      for (int i = 0; i < 100; i++)
        if (m_map[i] == k && m_stat[i] == 0) untouched = 1;
      if (untouched) begin
        res = 2;
      end else begin
        for (int i = 0; i < 100; i++)
          if (m_map[i] == k) m_stat[i] = 3;
        m_left--;
        if (m_left == 0) m_over = 1;
        res = 3;
        lat = 101;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic place(input int r, input int c, input int id);
    place_we = 1'b1;
    place_row = 4'(r);
    place_col = 4'(c);
    place_id = 3'(id);
    tick();
    place_we = 1'b0;
    if (r < 10 && c < 10 && id >= 1 && id <= 5 && m_map[r*10+c] == 0)
      m_map[r*10+c] = id;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (ships_on_board() != 0) m_left = ships_on_board();
  endtask

  task automatic fire(input int r, input int c, input string tag);
    int exp_res, exp_lat, lat, n;
    bit ready_bad;
    n = 0;
    while (!fire_ready && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!fire_ready) begin
      failures++;
      $display("FAIL %s wait_ready: fire_ready=%b required 1", tag, fire_ready);
      return;
    end
    model_shot(r, c, exp_res, exp_lat);
    fire_valid = 1'b1;
    fire_row = 4'(r);
    fire_col = 4'(c);
    tick();
    fire_valid = 1'b0;
    lat = 0;
    ready_bad = 0;
    while (!result_valid && lat < 200) begin
      if (fire_ready) ready_bad = 1;
      tick();
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d required %0d", tag, lat, exp_lat);
    end
    checks++;
    if (ready_bad) begin
      failures++;
      $display("FAIL %s ready_busy: fire_ready high while busy, required 0", tag);
    end
    checks++;
    if (result !== 2'(exp_res)) begin
      failures++;
      $display("FAIL %s result: got %b required %b", tag, result, 2'(exp_res));
    end
    checks++;
    if (cell_status_flat !== model_flat()) begin
      failures++;
      $display("FAIL %s board: got %h required %h", tag,
               cell_status_flat, model_flat());
    end
    checks++;
    if (ships_left !== 3'(m_left) || game_over !== m_over) begin
      failures++;
      $display("FAIL %s ships: got left=%0d over=%b required left=%0d over=%b",
               tag, ships_left, game_over, m_left, m_over);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0 || result !== 2'(exp_res)
        || fire_ready !== !m_over) begin
      failures++;
      $display("FAIL %s after: got rv=%b res=%b rdy=%b required 0 %b %b",
               tag, result_valid, result, fire_ready, 2'(exp_res), !m_over);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (fire_ready !== 0 || result_valid !== 0 || result !== 2'b00
        || ships_left !== 0 || game_over !== 0 || cell_status_flat !== '0) begin
      failures++;
      $display("FAIL reset: got rdy=%b rv=%b res=%b left=%0d over=%b flat_nz=%b required all 0",
               fire_ready, result_valid, result, ships_left, game_over,
               |cell_status_flat);
    end
  endtask

  task automatic test_start_empty();
    pulse_start();
    tick();
    checks++;
    if (fire_ready !== 0 || ships_left !== 0) begin
      failures++;
      $display("FAIL start_empty: got rdy=%b left=%0d required 0 0",
               fire_ready, ships_left);
    end
  endtask

  task automatic test_setup();
    place(0, 0, 1);
    place(0, 1, 1);
    place(3, 3, 2);
    place(3, 4, 2);
    place(3, 5, 2);
    place(3, 4, 3);
    place(12, 2, 3);
    place(2, 2, 0);
    place(2, 2, 6);
    pulse_start();
    checks++;
    if (ships_left !== 3'(m_left) || fire_ready !== 1'b1
        || cell_status_flat !== '0) begin
      failures++;
      $display("FAIL setup_start: got left=%0d rdy=%b required %0d 1",
               ships_left, fire_ready, m_left);
    end
    place(7, 7, 4);
    checks++;
    if (ships_left !== 3'd2) begin
      failures++;
      $display("FAIL setup_late_place: got left=%0d required 2", ships_left);
    end
  endtask

  task automatic test_miss();
    fire(5, 5, "miss");
    checks++;
    if (cell_status_flat[111:110] !== 2'b01) begin
      failures++;
      $display("FAIL miss_bits: got %b required 01", cell_status_flat[111:110]);
    end
  endtask

  task automatic test_hit_repeat();
    fire(3, 4, "hit");
    fire(3, 4, "repeat");
    fire(12, 0, "oob_row");
    fire(0, 15, "oob_col");
  endtask

  task automatic test_sink();
    fire(3, 3, "hit2");
    fire(3, 5, "sink");
  endtask

  task automatic test_random();
    int r, c;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(4, 9);
      c = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) c = $urandom_range(10, 15);
      fire(r, c, "random");
    end
  endtask

  task automatic test_game_over();
    fire(0, 0, "last_hit");
    fire(0, 1, "last_sink");
  endtask

  task automatic test_done();
    logic [199:0] snap;
    bit bad;
    snap = cell_status_flat;
    bad = 0;
    fire_valid = 1'b1;
    fire_row = 4'd9;
    fire_col = 4'd9;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fire_ready || result_valid) bad = 1;
    end
    fire_valid = 1'b0;
    checks++;
    if (bad || cell_status_flat !== snap || game_over !== 1'b1
        || result !== 2'b11) begin
      failures++;
      $display("FAIL done_hold: got bad=%b over=%b res=%b required 0 1 11",
               bad, game_over, result);
    end
  endtask

  task automatic test_reset_mid_scan();
    bit seen;
    do_reset();
    place(9, 9, 4);
    pulse_start();
    fire_valid = 1'b1;
    fire_row = 4'd9;
    fire_col = 4'd9;
    tick();
    fire_valid = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_clear();
    checks++;
    if (fire_ready !== 0 || result_valid !== 0 || result !== 2'b00
        || ships_left !== 0 || game_over !== 0 || cell_status_flat !== '0) begin
      failures++;
      $display("FAIL mid_scan_reset: got rdy=%b rv=%b res=%b left=%0d flat_nz=%b required all 0",
               fire_ready, result_valid, result, ships_left, |cell_status_flat);
    end
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (result_valid || fire_ready) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mid_scan_pulse: got late activity, required none");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    place_we = 1'b0;
    place_row = '0;
    place_col = '0;
    place_id = '0;
    start = 1'b0;
    fire_valid = 1'b0;
    fire_row = '0;
    fire_col = '0;
    tick();
    test_reset();
    test_start_empty();
    test_setup();
    test_miss();
    test_hit_repeat();
    test_sink();
    test_random();
    test_game_over();
    test_done();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
